instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the 8-bit processor. Fetches an 8-bit instruction
//  (opcode = ir[7:5], operand = ir[4:0]) over an imem req/ack handshake and decodes the opcode.
//  Drives the datapath strobes J, JC, INA, RM, WM, SIN, SOUT, WR, NEQ with correct per-cycle timing.
//  Owns the PC, and waits on data-memory ack for MR/MW.
// PARAMETERS
//  PC_W    8   program counter / imem address width (>= 5)
// PORTS
//  clk        in   1     single clock, all state on rising edge
//  rst        in   1     synchronous, active-high reset
//  imem_req   out  1     instruction fetch request, held until imem_ack
//  imem_addr  out  PC_W  fetch address (= pc while imem_req)
//  imem_ack   in   1     fetch complete; imem_data valid this cycle
//  imem_data  in   8     instruction byte
//  dmem_ack   in   1     data-memory access complete (MR/MW)
//  eq         in   1     datapath equality flag, sampled in EXEC
//  pc         out  PC_W  current program counter
//  ir         out  8     latched instruction
//  j,jc,ina,rm,wm,sin,sout,wr,neq  out 1 each   datapath control strobes
//  retire     out  1     one-cycle pulse when an instruction completes
//  step       in   1     single-step advance (present only with SINGLE_STEP_EN)
// BEHAVIOUR
//  Reset: state=FETCH, pc=0, ir=0, every output 0; a reset cycle aborts any in-flight access.
//  States: FETCH -> DECODE -> EXEC -> (MEM) -> FETCH.
//  FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_data, pc<=pc+1 (wraps 2^PC_W-1 -> 0), go DECODE.
//  DECODE: 1 cycle, strobes 0; decode registered for EXEC.
//  EXEC (1 cycle) strobes by opcode:
//   000 R: sout | 001 MFI: sin,ina | 010 MW: wm | 011 MR: rm | 100 J: j | 101 JCE: jc
//   110 MB: wr | 111 JCN: jc,neq
//  Memory ops (010, 011) go EXEC->MEM; all others EXEC->FETCH with retire=1 in EXEC.
//  MEM: hold rm or wm until dmem_ack; MR asserts wr in the dmem_ack cycle only. Exit to FETCH, retire=1.
//  dmem_ack arriving in EXEC completes in EXEC itself (MEM skipped); dmem_ack outside EXEC/MEM ignored.
//  Jumps: target = zero-extended ir[4:0]. J loads pc<=target in EXEC.
//   JCE loads if eq=1; JCN loads if eq=0; otherwise pc unchanged (already +1).
//  imem_ack outside FETCH ignored; imem_req never drops before ack except on rst.
//  Latency: non-memory instr = fetch cycles + 2; minimum 3 cycles with same-cycle ack.
//  Strobes are registered outputs, glitch-free, mutually as table above, 0 in FETCH/DECODE.
// CONFIGURATION
//  SINGLE_STEP_EN defined: extra HOLD state after every retire and after reset.
//   HOLD leaves all strobes 0 and imem_req 0; step=1 (sampled) -> FETCH.
//  Not defined: no step port, no HOLD state; free-running FETCH after retire/reset.
// STRUCTURE
//  Package ctrl_pkg: opcode localparams (OP_R..OP_JCN), state encoding, ctl_t struct of the 9 strobes.
//  Sub-module opcode_decode: combinational opcode -> ctl_t + is_mem/is_jump flags; FSM/PC in top.
// TESTING
//  Reset: hold rst 2 cycles mid-fetch -> pc=0, imem_req=1 at addr 0 on the first post-reset cycle, all strobes 0.
//  Straight-line: imem 0x00,0x20,0xC0 with same-cycle ack -> sout, sin+ina, wr each 1 cycle, retire every 3rd cycle.
//  MR with dmem_ack after 4 cycles: rm high 5 cycles (EXEC+MEM), wr only with ack, then pc advances to next fetch.
//  J 0x9F at pc=0x10 -> next imem_addr=0x1F. JCE 0xA5: eq=1 -> 0x05; eq=0 -> pc+1.
//  JCN 0xE3: eq=0 -> 0x03 with jc+neq; pc=0xFF fetch wraps to pc=0x00.
//  SINGLE_STEP_EN: no fetch until step; one step pulse -> exactly one retire, then HOLD again.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the 8-bit processor sequencer: opcodes, FSM state codes, strobe bundle.
package ctrl_pkg;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPND_W  = 5;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_MFI = 3'b001;
    localparam logic [2:0] OP_MW  = 3'b010;
    localparam logic [2:0] OP_MR  = 3'b011;
    localparam logic [2:0] OP_J   = 3'b100;
    localparam logic [2:0] OP_JCE = 3'b101;
    localparam logic [2:0] OP_MB  = 3'b110;
    localparam logic [2:0] OP_JCN = 3'b111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // Datapath control strobes driven during EXEC/MEM
    typedef struct packed {
        logic j;
        logic jc;
        logic ina;
        logic rm;
        logic wm;
        logic sin;
        logic sout;
        logic wr;
        logic neq;
    } ctl_t;

    localparam ctl_t CTL_NONE = '0;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decoder: maps the 3-bit opcode to the strobe bundle and class flags.
module opcode_decode
    import ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctl_t             ctl_o,
    output logic             is_mem_o,
    output logic             is_jump_o
);

    always_comb begin
        ctl_o     = CTL_NONE;
        is_mem_o  = 1'b0;
        is_jump_o = 1'b0;
        case (opcode_i)
            OP_R:   ctl_o.sout = 1'b1;
            OP_MFI: begin
                ctl_o.sin = 1'b1;
                ctl_o.ina = 1'b1;
            end
            OP_MW: begin
                ctl_o.wm = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_MR: begin
                ctl_o.rm = 1'b1;
                is_mem_o = 1'b1;
            end
            OP_J: begin
                ctl_o.j   = 1'b1;
                is_jump_o = 1'b1;
            end
            OP_JCE: begin
                ctl_o.jc  = 1'b1;
                is_jump_o = 1'b1;
            end
            OP_MB:  ctl_o.wr = 1'b1;
            OP_JCN: begin
                ctl_o.jc  = 1'b1;
                ctl_o.neq = 1'b1;
                is_jump_o = 1'b1;
            end
            default: ctl_o = CTL_NONE;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer owning the PC and the datapath strobes.
// Optional SINGLE_STEP_EN adds a HOLD state (after reset and every retire) released by step.
module instr_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               dmem_ack,
    input  logic               eq,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               j,
    output logic               jc,
    output logic               ina,
    output logic               rm,
    output logic               wm,
    output logic               sin,
    output logic               sout,
    output logic               wr,
    output logic               neq,
    output logic               retire
`ifdef SINGLE_STEP_EN
    ,
    input  logic               step
`endif
);

`ifdef SINGLE_STEP_EN
    localparam logic [2:0] IDLE_ST = ST_HOLD;
`else
    localparam logic [2:0] IDLE_ST = ST_FETCH;
`endif

    logic [2:0]         state_q,  state_d;
    logic [PC_W-1:0]    pc_q,     pc_d;
    logic [INSTR_W-1:0] ir_q,     ir_d;
    ctl_t               ctl_q,    ctl_d;
    logic               mem_q,    mem_d;
    logic               jump_q,   jump_d;
    logic               retire_q, retire_d;
    logic               req_q,    req_d;
    logic               mem_done;
    logic               take;

    ctl_t dec_ctl;
    logic dec_mem;
    logic dec_jump;

    opcode_decode u_dec (
        .opcode_i  (ir_q[INSTR_W-1 -: OPC_W]),
        .ctl_o     (dec_ctl),
        .is_mem_o  (dec_mem),
        .is_jump_o (dec_jump)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE_ST;
            pc_q     <= '0;
            ir_q     <= '0;
            ctl_q    <= CTL_NONE;
            mem_q    <= 1'b0;
            jump_q   <= 1'b0;
            retire_q <= 1'b0;
            req_q    <= (IDLE_ST == ST_FETCH);
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ctl_q    <= ctl_d;
            mem_q    <= mem_d;
            jump_q   <= jump_d;
            retire_q <= retire_d;
            req_q    <= req_d;
        end
    end

    // Next-state, PC and strobe staging; strobes are loaded in DECODE so they are live for EXEC
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ctl_d    = ctl_q;
        mem_d    = mem_q;
        jump_d   = jump_q;
        retire_d = 1'b0;
        mem_done = 1'b0;
        take     = jump_q & (ctl_q.j | (ctl_q.jc & (eq ^ ctl_q.neq)));

        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctl_d    = dec_ctl;
                mem_d    = dec_mem;
                jump_d   = dec_jump;
                retire_d = ~dec_mem;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                if (mem_q) begin
                    if (dmem_ack) begin
                        mem_done = 1'b1;
                        ctl_d    = CTL_NONE;
                        mem_d    = 1'b0;
                        state_d  = IDLE_ST;
                    end else begin
                        state_d  = ST_MEM;
                    end
                end else begin
                    if (take) begin
                        pc_d = PC_W'(ir_q[OPND_W-1:0]);
                    end
                    ctl_d   = CTL_NONE;
                    jump_d  = 1'b0;
                    state_d = IDLE_ST;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    mem_done = 1'b1;
                    ctl_d    = CTL_NONE;
                    mem_d    = 1'b0;
                    state_d  = IDLE_ST;
                end
            end
`ifdef SINGLE_STEP_EN
            ST_HOLD: begin
                if (step) begin
                    state_d = ST_FETCH;
                end
            end
`endif
            default: state_d = IDLE_ST;
        endcase

        req_d = (state_d == ST_FETCH);
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign j         = ctl_q.j;
    assign jc        = ctl_q.jc;
    assign ina       = ctl_q.ina;
    assign rm        = ctl_q.rm;
    assign wm        = ctl_q.wm;
    assign sin       = ctl_q.sin;
    assign sout      = ctl_q.sout;
    assign neq       = ctl_q.neq;
    // Data-memory completion is visible in the ack cycle itself: MR write-back and retire
    assign wr        = ctl_q.wr | (ctl_q.rm & mem_done);
    assign retire    = retire_q | mem_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a driver plays imem/dmem, a monitor checks each retire.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       dmem_ack = 1'b0;
    logic       eq = 1'b0;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       j, jc, ina, rm, wm, sin, sout, wr, neq, retire;
`ifdef SINGLE_STEP_EN
    logic       step = 1'b0;
    localparam logic REQ_AFTER_RST = 1'b0;
`else
    localparam logic REQ_AFTER_RST = 1'b1;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] ir;
        logic [8:0] vec;
        int         scyc;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] model_pc = 8'h00;
    logic [8:0] vec_w;
    assign vec_w = {j, jc, ina, rm, wm, sin, sout, wr, neq};

    instr_sequencer #(.PC_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .dmem_ack  (dmem_ack),
        .eq        (eq),
        .pc        (pc),
        .ir        (ir),
        .j         (j),
        .jc        (jc),
        .ina       (ina),
        .rm        (rm),
        .wm        (wm),
        .sin       (sin),
        .sout      (sout),
        .wr        (wr),
        .neq       (neq),
        .retire    (retire)
`ifdef SINGLE_STEP_EN
        ,
        .step      (step)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Strobe vector order {j,jc,ina,rm,wm,sin,sout,wr,neq}
    function automatic logic [8:0] exp_strobes(input logic [2:0] op);
        case (op)
            3'b000:  return 9'b0_0_0_0_0_0_1_0_0;
            3'b001:  return 9'b0_0_1_0_0_1_0_0_0;
            3'b010:  return 9'b0_0_0_0_1_0_0_0_0;
            3'b011:  return 9'b0_0_0_1_0_0_0_1_0;
            3'b100:  return 9'b1_0_0_0_0_0_0_0_0;
            3'b101:  return 9'b0_1_0_0_0_0_0_0_0;
            3'b110:  return 9'b0_0_0_0_0_0_0_1_0;
            default: return 9'b0_1_0_0_0_0_0_0_1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl: FETCH cycles without ack before the acking cycle; dl: cycles after EXEC until dmem_ack
    task automatic do_instr(input logic [7:0] ins, input int fl, input int dl, input logic eqv);
        exp_t       e;
        logic [2:0] op;
        logic       is_mem;
        logic       take;
        int         n;
        op     = ins[7:5];
        is_mem = (op == 3'b010) || (op == 3'b011);
`ifdef SINGLE_STEP_EN
        check("hold_req", 32'(imem_req), 32'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
        n = 0;
        while (!imem_req && n < 40) begin
            tick();
            n++;
        end
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(model_pc));
        check("pc_out", 32'(pc), 32'(model_pc));
        e.ir   = ins;
        e.vec  = exp_strobes(op);
        e.scyc = is_mem ? dl + 1 : 1;
        e.lat  = fl + 3 + (is_mem ? dl : 0);
        exp_q.push_back(e);
        eq = eqv;
        repeat (fl) tick();
        imem_ack  = 1'b1;
        imem_data = ins;
        tick();
        // DECODE: stray acks here must be ignored
        imem_ack  = 1'b1;
        imem_data = 8'($urandom);
        dmem_ack  = 1'b1;
        tick();
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        if (is_mem) begin
            repeat (dl) tick();
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
        end else begin
            tick();
        end
        take = (op == 3'b100) || (op == 3'b101 && eqv) || (op == 3'b111 && !eqv);
        model_pc = take ? {3'b000, ins[4:0]} : model_pc + 8'd1;
    endtask

    // Monitor: on each retire pop the oldest expectation and compare
    initial begin
        exp_t       e;
        logic       act;
        int         cyc;
        int         scnt;
        logic [8:0] orv;
        act = 1'b0; cyc = 0; scnt = 0; orv = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 1'b0; cyc = 0; scnt = 0; orv = '0;
            end else begin
                if (imem_req) act = 1'b1;
                if (act) cyc++;
                if (vec_w != 9'd0) scnt++;
                orv = orv | vec_w;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_retire", 32'(retire), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ir", 32'(ir), 32'(e.ir));
                        check("retire_strobes", 32'(vec_w), 32'(e.vec));
                        check("strobe_union", 32'(orv), 32'(e.vec));
                        check("strobe_cycles", 32'(scnt), 32'(e.scyc));
                        check("latency", 32'(cyc), 32'(e.lat));
                    end
                    act = 1'b0; cyc = 0; scnt = 0; orv = '0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops [5];
        int         k;
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req", 32'(imem_req), 32'(REQ_AFTER_RST));
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_strobes", 32'(vec_w), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);

        // Straight-line R, MFI, MB with same-cycle ack
        do_instr(8'h00, 0, 0, 1'b0);
        do_instr(8'h20, 0, 0, 1'b0);
        do_instr(8'hC0, 0, 0, 1'b0);
        // MR with a 4-cycle data-memory wait, MW completing in EXEC
        do_instr(8'h65, 1, 4, 1'b0);
        do_instr(8'h4A, 0, 0, 1'b0);
        // Jumps
        do_instr(8'h90, 2, 0, 1'b0);
        do_instr(8'h9F, 0, 0, 1'b1);
        do_instr(8'hA5, 0, 0, 1'b1);
        do_instr(8'hA5, 1, 0, 1'b0);
        do_instr(8'hE3, 0, 0, 1'b1);
        do_instr(8'hE3, 0, 0, 1'b0);

        // Random non-jump traffic up to the top of the address space, then wrap
        k = 0;
        while (model_pc != 8'hFF && k < 300) begin
            do_instr({ops[$urandom_range(4)], 5'($urandom)}, $urandom_range(2),
                     $urandom_range(3), 1'($urandom));
            k++;
        end
        do_instr(8'h00, 0, 0, 1'b0);
        do_instr(8'hE3, 0, 0, 1'b1);
        do_instr(8'h20, 1, 0, 1'b0);

        // Reset in the middle of a fetch
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        tick();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_pc = 8'h00;
        check("rst2_req", 32'(imem_req), 32'(REQ_AFTER_RST));
        check("rst2_addr", 32'(imem_addr), 32'd0);
        check("rst2_pc", 32'(pc), 32'd0);
        check("rst2_strobes", 32'(vec_w), 32'd0);
        check("rst2_retire", 32'(retire), 32'd0);
        do_instr(8'hC7, 0, 0, 1'b0);
        do_instr(8'h61, 0, 2, 1'b0);

        repeat (2) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
